// File: rtl/matrix_result_serializer.sv
// Captures a packed row-major result matrix on start and streams its elements
// one per valid/ready beat, tagged with row/col indices, a last flag and a done pulse.
module matrix_result_serializer #(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int ELEM_W = 8,
  localparam int MAT_LEN = ROWS * COLS * ELEM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAT_LEN-1:0] mat_in,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ELEM_W-1:0]  out_data,
  output logic [7:0]         out_row,
  output logic [7:0]         out_col,
  output logic               out_last,
  output logic               done
);

  localparam int NUM = ROWS * COLS;
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);
  localparam logic [7:0] COL_MAX = 8'(COLS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [MAT_LEN-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   idx_nxt;
  logic [ELEM_W-1:0]  data_q, data_d;
  logic [7:0]         row_q, row_d;
  logic [7:0]         col_q, col_d;
  logic               last_q, last_d;
  logic               done_q, done_d;

  // Element k occupies the k-th byte counted down from the MSB end of the bus.
  function automatic logic [ELEM_W-1:0] elem_at(input logic [MAT_LEN-1:0] bus,
                                                input logic [IDX_W-1:0]   idx);
    elem_at = '0;
    for (int i = 0; i < NUM; i++) begin
      if (idx == IDX_W'(i)) elem_at = bus[MAT_LEN-1-i*ELEM_W -: ELEM_W];
    end
  endfunction

  assign idx_nxt = idx_q + IDX_W'(1);

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    data_d   = data_q;
    row_d    = row_q;
    col_d    = col_q;
    last_d   = last_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SEND;
          shadow_d = mat_in;
          idx_d    = '0;
          row_d    = '0;
          col_d    = '0;
          data_d   = mat_in[MAT_LEN-1 -: ELEM_W];
          last_d   = (NUM == 1);
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_nxt;
            data_d = elem_at(shadow_q, idx_nxt);
            last_d = (idx_nxt == LAST_IDX);
            if (col_q == COL_MAX) begin
              col_d = '0;
              row_d = row_q + 8'd1;
            end else begin
              col_d = col_q + 8'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      // NOTE: the shadow bus is explicitly cleared on reset so no stale matrix survives an abort.
      shadow_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      row_q    <= row_d;
      col_q    <= col_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q == SEND);
  assign out_valid = (state_q == SEND);
  assign out_data  = data_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Scoreboard bench: a 3x2 serializer under directed and random traffic, plus a
// short directed run of a 1x1 instance where the first element is also last.
module tb_matrix_result_serializer;

  localparam int ROWS = 3;
  localparam int COLS = 2;
  localparam int EW = 8;
  localparam int N = ROWS * COLS;
  localparam int MAT_LEN = N * EW;

  logic               clk = 1'b0;
  logic               rst, start, out_ready;
  logic [MAT_LEN-1:0] mat_in;
  logic               busy, out_valid, out_last, done;
  logic [EW-1:0]      out_data;
  logic [7:0]         out_row, out_col;

  logic          start1, ready1;
  logic [EW-1:0] mat1;
  logic          busy1, valid1, last1, done1;
  logic [EW-1:0] data1;
  logic [7:0]    row1, col1;

  always #5 clk = ~clk;

  matrix_result_serializer #(.ROWS(ROWS), .COLS(COLS), .ELEM_W(EW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .mat_in(mat_in), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .done(done)
  );

  matrix_result_serializer #(.ROWS(1), .COLS(1), .ELEM_W(EW)) u_one (
    .clk(clk), .rst(rst), .start(start1), .mat_in(mat1), .busy(busy1),
    .out_valid(valid1), .out_ready(ready1), .out_data(data1),
    .out_row(row1), .out_col(col1), .out_last(last1), .done(done1)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] row;
    logic [7:0] col;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int    rem = 0;
  logic  exp_done = 1'b0;
  logic  exp_zero = 1'b1;
  logic  mon_en = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the matrix is a list of N elements; element k is byte k from the MSB end.
  always @(posedge clk) begin
    if (!rst) begin
      sb.delete();
      rem      = 0;
      exp_done = 1'b0;
      exp_zero = 1'b1;
    end else if (rem > 0) begin
      exp_done = (rem == 1) && out_ready;
      if (out_ready) rem--;
    end else begin
      exp_done = 1'b0;
      if (start) begin
        for (int k = 0; k < N; k++) begin
          logic [MAT_LEN-1:0] sh;
          beat_t b;
          sh     = mat_in >> ((N - 1 - k) * EW);
          b.data = sh[7:0];
          b.row  = 8'(k / COLS);
          b.col  = 8'(k % COLS);
          b.last = (k == N - 1);
          sb.push_back(b);
        end
        rem      = N;
        exp_zero = 1'b0;
      end
    end
  end

  // Monitor: compares the presented beat with the scoreboard head, pops on a handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(busy), 32'(rem > 0));
      check("valid", 32'(out_valid), 32'(rem > 0));
      check("done", 32'(done), 32'(exp_done));
      if (exp_zero) begin
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_row", 32'(out_row), 32'd0);
        check("rst_col", 32'(out_col), 32'd0);
      end
      if (rem == 0) check("last_idle", 32'(out_last), 32'd0);
      if (rem > 0) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          check("data", 32'(out_data), 32'(sb[0].data));
          check("row", 32'(out_row), 32'(sb[0].row));
          check("col", 32'(out_col), 32'(sb[0].col));
          check("last", 32'(out_last), 32'(sb[0].last));
          if (out_ready && rst) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (N + 3) step();
  endtask

  initial begin
    logic [63:0] rnd;
    rst = 1'b0; start = 1'b0; out_ready = 1'b0; mat_in = '0;
    start1 = 1'b0; ready1 = 1'b0; mat1 = '0;
    step();
    mon_en = 1'b1;
    step();
    rst = 1'b1;
    step();

    // Full-rate stream with row/col wrap
    out_ready = 1'b1;
    mat_in = 48'h0A0B0C0D0E0F;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (N + 3) step();

    // Backpressure on the second element
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    out_ready = 1'b0;
    repeat (3) step();
    drain();

    // start and bus changes while busy are ignored
    mat_in = 48'h112233445566;
    start = 1'b1;
    step();
    mat_in = '1;
    repeat (3) step();
    start = 1'b0;
    drain();

    // Reset mid-stream, then a fresh stream
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    mat_in = 48'hA0B0C0D0E0F0;
    start = 1'b1;
    step();
    start = 1'b0;
    drain();

    // Back-to-back streams with start held high through done
    mat_in = 48'h010203040506;
    start = 1'b1;
    repeat (2 * N + 3) step();
    drain();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rnd       = {$urandom(), $urandom()};
      mat_in    = rnd[MAT_LEN-1:0];
      start     = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) != 0);
      step();
    end
    rst = 1'b1;
    drain();
    check("sb_drained", 32'(sb.size()), 32'd0);

    // 1x1 instance: first element is also last
    mat1 = 8'h5A;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    mat1 = 8'hFF;
    check("one_valid", 32'(valid1), 32'd1);
    check("one_busy", 32'(busy1), 32'd1);
    check("one_last", 32'(last1), 32'd1);
    check("one_data", 32'(data1), 32'h5A);
    check("one_rowcol", {16'd0, row1, col1}, 32'd0);
    step();
    check("one_stall_valid", 32'(valid1), 32'd1);
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    check("one_done", 32'(done1), 32'd1);
    check("one_valid_after", 32'(valid1), 32'd0);
    check("one_last_after", 32'(last1), 32'd0);
    step();
    check("one_done_pulse", 32'(done1), 32'd0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_result_serializer.md
Name: matrix_result_serializer

Overview:
Transmit-side companion to the parallel matrix multiplier. The multiplier produces a flattened, packed result matrix: row-major, 8-bit elements, element [0][0] in the most-significant byte. This block captures that packed bus on a start strobe and streams the elements out one per beat on a valid/ready handshake, tagged with row/col indices and a last flag. It sits between the multiplier result bus and any downstream consumer (printer, memory writer, next compute stage).

Parameters:
- ROWS, 2, rows in the result matrix (1..255)
- COLS, 2, columns in the result matrix (1..255)
- ELEM_W, 8, bits per element
- MAT_LEN, ROWS*COLS*ELEM_W (32), width of the packed matrix bus; derived, do not override

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- start  in  1  capture request; sampled only when idle
- mat_in  in  MAT_LEN  packed matrix, element [r][c] at bits [MAT_LEN-1-(r*COLS+c)*ELEM_W -: ELEM_W]
- busy  out  1  high from capture until the final transfer completes
- out_valid  out  1  current element valid
- out_ready  in  1  consumer accepts the element
- out_data  out  ELEM_W  current element
- out_row  out  8  row index of out_data
- out_col  out  8  column index of out_data
- out_last  out  1  high while the final element (ROWS-1, COLS-1) is presented
- done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; busy, out_valid, out_last and done are 0; out_data, out_row and out_col are 0; the shadow register is cleared. Reset has priority over all other inputs and aborts any stream in progress with no done pulse.
- States: IDLE, SEND.
- IDLE, start==1 at an edge:
  - mat_in is copied into the internal shadow register; index = 0.
  - state goes to SEND; busy = 1; out_valid = 1; element [0][0] is presented.
  - Latency: start sampled at edge t0 puts valid data on the outputs immediately after t0.
- IDLE, start==0: all outputs hold their values, except done, which is forced to 0.
- SEND, transfer (out_valid & out_ready at an edge):
  - index increments.
  - col wraps from COLS-1 to 0 and row increments.
  - The next element, row, col and last are presented on the next cycle.
- SEND, stall (out_valid & !out_ready): out_data, out_row, out_col and out_last are held stable. Once out_valid rises it must not drop until the transfer occurs.
- Final transfer (index == ROWS*COLS-1 and out_ready):
  - state goes to IDLE; out_valid, out_last and busy go to 0.
  - done = 1 for exactly one cycle.
- Throughput: with out_ready held high, one element per cycle. Start to done takes ROWS*COLS+1 edges.
- start while busy: ignored and not queued. Changes to mat_in after capture have no effect on the stream.
- start in the same cycle done is high: accepted, because the block is already IDLE. A back-to-back stream begins and done still pulses.
- Index counter is wide enough for ROWS*COLS-1 and never exceeds it. For ROWS=COLS=1, the first element is also last.
- No arithmetic is performed on the data. Elements are bit-exact slices of the captured bus; sign is not interpreted.

Test Plan:
1. 2x2, mat_in=32'h01020304, start pulse, out_ready=1 -> out_data 01,02,03,04 on consecutive cycles; (row,col)=(0,0),(0,1),(1,0),(1,1); out_last only with 04; done pulse on the following cycle; busy low afterwards.
2. Backpressure: same stimulus, out_ready=0 for 3 cycles while 02 is presented -> out_data=02, row=0, col=1 held for 4 cycles; no element dropped or duplicated; done arrives 3 cycles later than in test 1.
3. Busy/start interaction: while streaming, mat_in=32'hFFFFFFFF and start pulsed -> stream continues 01..04 unchanged; exactly one done; no second stream.
4. Reset mid-stream: assert rst=0 after 02 transfers -> next cycle all outputs 0, IDLE, no done. New start with 32'hA0B0C0D0 -> streams A0,B0,C0,D0 from (0,0).
5. Non-square: ROWS=3, COLS=2, mat_in=48'h0A0B0C0D0E0F -> 0A(0,0) 0B(0,1) 0C(1,0) 0D(1,1) 0E(2,0) 0F(2,1); out_last with 0F.
6. Back-to-back: start held high through done -> second stream starts in the done cycle, with no gap beyond one cycle; both streams are complete and ordered.
